// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits (8E1).
module uart_rx #(
   parameter int unsigned CLK_FREQ = 27000000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned DIV      = (CLK_FREQ + BAUD * 8) / (BAUD * 16)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       data_ready,
   output logic       framing_error,
   output logic       parity_error,
   output logic       busy
);

   localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UART_RX_PARITY_EN
      StParity,
`endif
      StStop,
      StWaitHigh
   } state_e;

   state_e            state_q, state_d;
   logic              rxd_meta_q, rxs_q;
   logic [DivW-1:0]   div_q, div_d;
   logic [3:0]        samp_q, samp_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        data_q, data_d;
   logic              dr_q, dr_d;
   logic              fe_q, fe_d;
   logic              tick;
   logic              mid_bit;
   logic              start_edge;
`ifdef UART_RX_PARITY_EN
   logic              pe_q, pe_d;
   logic              par_err_q, par_err_d;
`endif

   // Synchronizer flops reset to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta_q <= 1'b1;
         rxs_q      <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxs_q      <= rxd_meta_q;
      end
   end

   assign tick       = (div_q == DivW'(DIV - 1));
   assign mid_bit    = tick && (samp_q == 4'd15);
   assign start_edge = (state_q == StIdle) && !rxs_q;

   always_comb begin
      div_d = div_q + 1'b1;
      if (start_edge || tick) begin
         div_d = '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      samp_d    = samp_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      data_d    = data_q;
      dr_d      = 1'b0;
      fe_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_d      = 1'b0;
      par_err_d = par_err_q;
`endif
      if (tick) begin
         samp_d = samp_q + 4'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (!rxs_q) begin
               state_d = StStart;
               samp_d  = 4'd0;
            end
         end
         StStart: begin
            // Re-check the line half a bit in; a high line means it was only a glitch.
            if (tick && (samp_q == 4'd7)) begin
               samp_d  = 4'd0;
               bit_d   = 3'd0;
               state_d = rxs_q ? StIdle : StData;
            end
         end
         StData: begin
            if (mid_bit) begin
               shift_d = {rxs_q, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (mid_bit) begin
               par_err_d = rxs_q ^ (^shift_q);
               state_d   = StStop;
            end
         end
`endif
         StStop: begin
            // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
            if (mid_bit) begin
               if (rxs_q) begin
                  state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                  if (par_err_q) begin
                     pe_d = 1'b1;
                  end else begin
                     data_d = shift_q;
                     dr_d   = 1'b1;
                  end
`else
                  data_d = shift_q;
                  dr_d   = 1'b1;
`endif
               end else begin
                  fe_d    = 1'b1;
                  state_d = StWaitHigh;
               end
            end
         end
         StWaitHigh: begin
            if (rxs_q) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         div_q     <= '0;
         samp_q    <= 4'd0;
         bit_q     <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         dr_q      <= 1'b0;
         fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_q      <= 1'b0;
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         samp_q    <= samp_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         dr_q      <= dr_d;
         fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
         pe_q      <= pe_d;
         par_err_q <= par_err_d;
`endif
      end
   end

   assign data          = data_q;
   assign data_ready    = dr_q;
   assign framing_error = fe_q;
`ifdef UART_RX_PARITY_EN
   assign parity_error  = pe_q;
`else
   assign parity_error  = 1'b0;
`endif
   assign busy          = (state_q != StIdle);

   a_status_exclusive : assert property (@(posedge clk) disable iff (rst)
      $onehot0({data_ready, framing_error, parity_error}));

endmodule
